adc_decimating_averager: RTL and testbench

Parametrised multi-channel boxcar averager and decimator for the fast ADC data path. It generalises the fixed 2:1 moving average to a runtime-selectable 2^L:1 decimation over any channel count and sample width, with a start-up discard window, a ready flag and sticky per-channel over-range flags. It sits between the LVDS deserialiser output and the downstream processing logic, in the deserialiser clock domain.

---
 rtl/adc_decimating_averager.sv | 194 +++++++++++++++++++
 tb/tb_adc_decimating_averager.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_decimating_averager.sv
// rtl/adc_decimating_averager.sv - multi-channel 2^L:1 boxcar averager and decimator
//
// Purpose: averages 2^L consecutive valid samples per channel (round half up,
// arithmetic shift) and emits one decimated sample per frame, after
// discarding a start-up window of SETTLE_SAMPLES valid samples. Also keeps
// sticky per-channel over-range flags for full-scale input codes.
//
// Ports:
//   clk             in   sample clock (deserialiser domain)
//   reset_n         in   asynchronous active-low reset
//   enable          in   run request; low aborts and returns to IDLE
//   log2_dec        in   requested L, latched on IDLE exit, clamped to MAX_LOG2_DEC
//   in_valid        in   qualifies in_data
//   in_data         in   packed samples, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   clear_overrange in   clears overrange (a simultaneous set wins)
//   out_valid       out  one-cycle strobe for a new averaged sample
//   out_data        out  averaged samples, same packing, held between strobes
//   ready           out  high while averaging is active
//   overrange       out  sticky per-channel full-scale flags
module adc_decimating_averager #(
   parameter int CHANNELS       = 4,
   parameter int DATA_WIDTH     = 16,
   parameter int MAX_LOG2_DEC   = 6,
   parameter int SETTLE_SAMPLES = 16,
   parameter int LW             = $clog2(MAX_LOG2_DEC + 1)
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           enable,
   input  logic [LW-1:0]                  log2_dec,
   input  logic                           in_valid,
   input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
   input  logic                           clear_overrange,
   output logic                           out_valid,
   output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
   output logic                           ready,
   output logic [CHANNELS-1:0]            overrange
);

   localparam int AW = DATA_WIDTH + MAX_LOG2_DEC;
   localparam int CW = MAX_LOG2_DEC;
   localparam logic [DATA_WIDTH-1:0] CODE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] CODE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_ACCUM  = 2'd2
   } state_e;

   state_e                          state_q, state_d;
   logic [LW-1:0]                   leff_q, leff_d;
   logic [15:0]                     settle_cnt_q, settle_cnt_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic signed [AW-1:0]            acc_q [CHANNELS];
   logic signed [AW-1:0]            acc_d [CHANNELS];
   logic [CHANNELS*DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic                            out_valid_q, out_valid_d;
   logic                            ready_q, ready_d;
   logic [CHANNELS-1:0]             ovr_q, ovr_d;

   logic [LW-1:0]                   leff_clamped;
   logic [CW-1:0]                   cnt_max;
   logic                            frame_last;
   logic                            settle_last;
   logic signed [AW:0]              round_bias;
   logic signed [AW:0]              samp_ext [CHANNELS];
   logic signed [AW:0]              total    [CHANNELS];
   logic signed [AW:0]              rounded  [CHANNELS];

   // Per-channel arithmetic. One guard bit above the accumulator width keeps
   // total + rounding bias from wrapping before the shift.
   always_comb begin
      leff_clamped = (log2_dec > LW'(MAX_LOG2_DEC)) ? LW'(MAX_LOG2_DEC) : log2_dec;
      cnt_max      = CW'((32'd1 << leff_q) - 32'd1);
      frame_last   = (cnt_q == cnt_max);
      settle_last  = ((32'(settle_cnt_q) + 32'd1) == 32'(SETTLE_SAMPLES));
      round_bias   = '0;
      if (leff_q != '0) begin
         round_bias = (AW+1)'(1) << (leff_q - LW'(1));
      end
      for (int k = 0; k < CHANNELS; k++) begin
         samp_ext[k] = {{(MAX_LOG2_DEC+1){in_data[k*DATA_WIDTH + DATA_WIDTH-1]}},
                        in_data[k*DATA_WIDTH +: DATA_WIDTH]};
         total[k]    = {acc_q[k][AW-1], acc_q[k]} + samp_ext[k];
         rounded[k]  = (total[k] + round_bias) >>> leff_q;
      end
   end

   // Over-range runs regardless of state; a new hit overrides the clear.
   always_comb begin
      ovr_d = ovr_q;
      for (int k = 0; k < CHANNELS; k++) begin
         if (in_valid && ((in_data[k*DATA_WIDTH +: DATA_WIDTH] == CODE_MAX) ||
                          (in_data[k*DATA_WIDTH +: DATA_WIDTH] == CODE_MIN))) begin
            ovr_d[k] = 1'b1;
         end else if (clear_overrange) begin
            ovr_d[k] = 1'b0;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      leff_d       = leff_q;
      settle_cnt_d = settle_cnt_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      out_data_d   = out_data_q;
      out_valid_d  = 1'b0;
      ready_d      = ready_q;

      if (!enable) begin
         // Abort: any partial frame is dropped; out_data keeps its last value.
         state_d      = ST_IDLE;
         settle_cnt_d = '0;
         cnt_d        = '0;
         ready_d      = 1'b0;
         for (int k = 0; k < CHANNELS; k++) acc_d[k] = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               leff_d       = leff_clamped;
               settle_cnt_d = '0;
               cnt_d        = '0;
               for (int k = 0; k < CHANNELS; k++) acc_d[k] = '0;
               if (SETTLE_SAMPLES == 0) begin
                  state_d = ST_ACCUM;
                  ready_d = 1'b1;
               end else begin
                  state_d = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               // The sample that completes the window is discarded too.
               if (in_valid) begin
                  if (settle_last) begin
                     state_d = ST_ACCUM;
                     ready_d = 1'b1;
                  end else begin
                     settle_cnt_d = settle_cnt_q + 16'd1;
                  end
               end
            end
            ST_ACCUM: begin
               if (in_valid) begin
                  if (frame_last) begin
                     out_valid_d = 1'b1;
                     cnt_d       = '0;
                     for (int k = 0; k < CHANNELS; k++) begin
                        acc_d[k] = '0;
                        out_data_d[k*DATA_WIDTH +: DATA_WIDTH] = rounded[k][DATA_WIDTH-1:0];
                     end
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                     for (int k = 0; k < CHANNELS; k++) acc_d[k] = total[k][AW-1:0];
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         leff_q       <= '0;
         settle_cnt_q <= '0;
         cnt_q        <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         ready_q      <= 1'b0;
         ovr_q        <= '0;
         for (int k = 0; k < CHANNELS; k++) acc_q[k] <= '0;
      end else begin
         state_q      <= state_d;
         leff_q       <= leff_d;
         settle_cnt_q <= settle_cnt_d;
         cnt_q        <= cnt_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         ready_q      <= ready_d;
         ovr_q        <= ovr_d;
         for (int k = 0; k < CHANNELS; k++) acc_q[k] <= acc_d[k];
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign ready     = ready_q;
   assign overrange = ovr_q;

endmodule

// File: tb/tb_adc_decimating_averager.sv
// tb/tb_adc_decimating_averager.sv - self-checking bench for adc_decimating_averager
module tb_adc_decimating_averager;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        enable;
   logic [2:0]  log2_dec;
   logic        in_valid;
   logic [63:0] in_data;
   logic        clear_overrange;

   logic        ov  [2];
   logic [63:0] od  [2];
   logic        rd  [2];
   logic [3:0]  orr [2];

   adc_decimating_averager #(.CHANNELS(4), .DATA_WIDTH(16), .MAX_LOG2_DEC(6), .SETTLE_SAMPLES(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .log2_dec(log2_dec),
      .in_valid(in_valid), .in_data(in_data), .clear_overrange(clear_overrange),
      .out_valid(ov[0]), .out_data(od[0]), .ready(rd[0]), .overrange(orr[0]));

   adc_decimating_averager #(.CHANNELS(4), .DATA_WIDTH(16), .MAX_LOG2_DEC(6), .SETTLE_SAMPLES(16)) u_dut16 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .log2_dec(log2_dec),
      .in_valid(in_valid), .in_data(in_data), .clear_overrange(clear_overrange),
      .out_valid(ov[1]), .out_data(od[1]), .ready(rd[1]), .overrange(orr[1]));

   // Reference model: 0 = idle, 1 = discarding, 2 = averaging.
   int          s_set [2] = '{0, 16};
   int          m_mode [2];
   int          m_leff [2];
   int          m_disc [2];
   int          m_cnt  [2];
   int          m_sum  [2][4];
   logic [63:0] e_data [2];
   logic        e_valid [2];
   logic        e_ready [2];
   logic [3:0]  e_ovr [2];

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_pulse [2] = '{0, 0};
   int interval   [2] = '{0, 0};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int chan(input logic [63:0] d, input int k);
      logic [15:0] s;
      s = d[k*16 +: 16];
      return int'($signed(s));
   endfunction

   function automatic logic [63:0] rnd_data();
      logic [63:0] d;
      int r;
      for (int k = 0; k < 4; k++) begin
         r = $urandom_range(0, 15);
         if (r == 0)      d[k*16 +: 16] = 16'h7FFF;
         else if (r == 1) d[k*16 +: 16] = 16'h8000;
         else             d[k*16 +: 16] = 16'($urandom);
      end
      return d;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_mode[i] = 0; m_leff[i] = 0; m_disc[i] = 0; m_cnt[i] = 0;
         for (int k = 0; k < 4; k++) m_sum[i][k] = 0;
         e_data[i] = '0; e_valid[i] = 1'b0; e_ready[i] = 1'b0; e_ovr[i] = '0;
      end
   endtask

   task automatic model_edge();
      int v;
      int frame;
      int bias;
      if (!reset_n) begin
         model_reset();
         return;
      end
      for (int i = 0; i < 2; i++) begin
         e_valid[i] = 1'b0;
         for (int k = 0; k < 4; k++) begin
            v = chan(in_data, k);
            if (in_valid && (v == 32767 || v == -32768)) e_ovr[i][k] = 1'b1;
            else if (clear_overrange)                   e_ovr[i][k] = 1'b0;
         end
         if (!enable) begin
            m_mode[i] = 0; e_ready[i] = 1'b0; m_cnt[i] = 0;
            for (int k = 0; k < 4; k++) m_sum[i][k] = 0;
         end else if (m_mode[i] == 0) begin
            m_leff[i] = (log2_dec > 6) ? 6 : int'(log2_dec);
            m_disc[i] = 0; m_cnt[i] = 0;
            for (int k = 0; k < 4; k++) m_sum[i][k] = 0;
            if (s_set[i] == 0) begin m_mode[i] = 2; e_ready[i] = 1'b1; end
            else m_mode[i] = 1;
         end else if (m_mode[i] == 1) begin
            if (in_valid) begin
               m_disc[i]++;
               if (m_disc[i] == s_set[i]) begin m_mode[i] = 2; e_ready[i] = 1'b1; end
            end
         end else if (in_valid) begin
            for (int k = 0; k < 4; k++) m_sum[i][k] += chan(in_data, k);
            m_cnt[i]++;
            frame = 1 << m_leff[i];
            if (m_cnt[i] == frame) begin
               bias = (m_leff[i] > 0) ? frame / 2 : 0;
               for (int k = 0; k < 4; k++) begin
                  e_data[i][k*16 +: 16] = 16'((m_sum[i][k] + bias) >>> m_leff[i]);
                  m_sum[i][k] = 0;
               end
               m_cnt[i] = 0;
               e_valid[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("dut%0d out_valid cyc%0d", i, cyc), 64'(ov[i]), 64'(e_valid[i]));
         chk($sformatf("dut%0d ready cyc%0d", i, cyc), 64'(rd[i]), 64'(e_ready[i]));
         chk($sformatf("dut%0d overrange cyc%0d", i, cyc), 64'(orr[i]), 64'(e_ovr[i]));
         chk($sformatf("dut%0d out_data cyc%0d", i, cyc), od[i], e_data[i]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
      check_all();
      for (int i = 0; i < 2; i++) begin
         if (ov[i] === 1'b1) begin
            interval[i] = cyc - last_pulse[i];
            last_pulse[i] = cyc;
         end
      end
   endtask

   initial begin
      int  nv;
      bit  seen_rdy;
      bit  seen_out;
      model_reset();
      reset_n = 1'b0; enable = 1'b0; log2_dec = '0; in_valid = 1'b0;
      in_data = '0; clear_overrange = 1'b0;
      step(); step();
      for (int i = 0; i < 2; i++) begin
         chk("reset out_valid", 64'(ov[i]), 64'd0);
         chk("reset out_data", od[i], 64'd0);
         chk("reset ready", 64'(rd[i]), 64'd0);
         chk("reset overrange", 64'(orr[i]), 64'd0);
      end
      reset_n = 1'b1;
      step();

      // Pass-through, L=0, ramp
      enable = 1'b1; log2_dec = 3'd0; in_valid = 1'b1;
      in_data = {16'd3, 16'd2, 16'd1, 16'd0};
      step();
      chk("passthru ready after enable", 64'(rd[0]), 64'd1);
      for (int n = 1; n <= 20; n++) begin
         in_data = {16'(n+3), 16'(n+2), 16'(n+1), 16'(n)};
         step();
         chk($sformatf("passthru ch0 n%0d", n), 64'(od[0][15:0]), 64'(n));
         chk($sformatf("passthru strobe n%0d", n), 64'(ov[0]), 64'd1);
      end

      // Rounding and sign, L=2
      enable = 1'b0; in_valid = 1'b0; step();
      enable = 1'b1; log2_dec = 3'd2; step();
      in_valid = 1'b1;
      in_data = {16'h8000, 16'h7FFF, 16'hFFFF, 16'd1}; step();
      in_data = {16'h8000, 16'h7FFF, 16'hFFFE, 16'd2}; step();
      step(); step();
      chk("round strobe", 64'(ov[0]), 64'd1);
      chk("round ch0 7/4", 64'(od[0][15:0]), 64'h0002);
      chk("round ch1 -7/4", 64'(od[0][31:16]), 64'hFFFE);
      chk("round ch2 max", 64'(od[0][47:32]), 64'h7FFF);
      chk("round ch3 min", 64'(od[0][63:48]), 64'h8000);

      // Settle and gaps, L=3, in_valid toggling
      enable = 1'b0; in_valid = 1'b0; step();
      enable = 1'b1; log2_dec = 3'd3; step();
      nv = 0; seen_rdy = 1'b0; seen_out = 1'b0;
      for (int j = 0; j < 120; j++) begin
         in_valid = (j % 2 == 0);
         in_data  = rnd_data();
         if (in_valid) nv++;
         step();
         if (!seen_rdy && rd[1] === 1'b1) begin
            seen_rdy = 1'b1;
            chk("settle ready after valid#", 64'(nv), 64'd16);
         end
         if (!seen_out && ov[1] === 1'b1) begin
            seen_out = 1'b1;
            chk("settle first out after valid#", 64'(nv), 64'd24);
         end
      end
      chk("settle ready seen", 64'(seen_rdy), 64'd1);
      chk("settle out seen", 64'(seen_out), 64'd1);
      chk("settle out period", 64'(interval[1]), 64'd16);

      // Abort mid-frame, then re-enable with L=1
      enable = 1'b0; in_valid = 1'b0; step();
      enable = 1'b1; log2_dec = 3'd4; step();
      in_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin in_data = rnd_data(); step(); end
      enable = 1'b0; in_data = rnd_data(); step();
      chk("abort ready low", 64'(rd[0]), 64'd0);
      chk("abort no strobe", 64'(ov[0]), 64'd0);
      enable = 1'b1; log2_dec = 3'd1;
      for (int j = 0; j < 60; j++) begin in_data = rnd_data(); step(); end
      chk("reenable period dut0", 64'(interval[0]), 64'd2);
      chk("reenable period dut16", 64'(interval[1]), 64'd2);

      // Clamp to 64 and ignore runtime log2_dec change
      enable = 1'b0; step();
      enable = 1'b1; log2_dec = 3'd7;
      for (int j = 0; j < 200; j++) begin
         if (j == 30) log2_dec = 3'd2;
         in_data = rnd_data();
         step();
      end
      chk("clamp period dut0", 64'(interval[0]), 64'd64);
      chk("clamp period dut16", 64'(interval[1]), 64'd64);

      // Over-range sticky / set-wins
      in_valid = 1'b0; clear_overrange = 1'b1; step();
      chk("ovr cleared", 64'(orr[0]), 64'd0);
      clear_overrange = 1'b0; in_valid = 1'b1;
      in_data = {16'h0000, 16'h7FFF, 16'h0000, 16'h0000}; step();
      chk("ovr set ch2", 64'(orr[0]), 64'b0100);
      clear_overrange = 1'b1;
      in_data = {16'h0000, 16'h8000, 16'h0000, 16'h0000}; step();
      chk("ovr set wins", 64'(orr[0]), 64'b0100);
      in_valid = 1'b0; step();
      chk("ovr clean clear", 64'(orr[1]), 64'd0);
      clear_overrange = 1'b0;

      // Asynchronous reset mid-frame
      enable = 1'b1; log2_dec = 3'd3; in_valid = 1'b1;
      for (int j = 0; j < 5; j++) begin in_data = rnd_data(); step(); end
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("async reset ready", 64'(rd[i]), 64'd0);
         chk("async reset out_data", od[i], 64'd0);
         chk("async reset overrange", 64'(orr[i]), 64'd0);
      end
      model_reset();
      step();
      reset_n = 1'b1;
      for (int j = 0; j < 20; j++) begin in_data = rnd_data(); step(); end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
